// File: rtl/lvds_align_ctrl_if.sv
// Control/status bundle between the camera LVDS receiver and its word-alignment
// sequencer. The sequencer takes the slave side.
interface lvds_align_ctrl_if #(
  parameter int NLANES = 5
);
  localparam int LW = (NLANES > 1) ? $clog2(NLANES) : 1;

  logic                  start;
  logic                  rx_locked;
  logic [8*NLANES-1:0]   lanes;
  logic [NLANES-1:0]     rxd_align;
  logic                  busy;
  logic                  done;
  logic [NLANES-1:0]     aligned;
  logic [NLANES-1:0]     failed;
  logic [LW-1:0]         lane;

  modport master (
    output start, rx_locked, lanes,
    input  rxd_align, busy, done, aligned, failed, lane
  );

  modport slave (
    input  start, rx_locked, lanes,
    output rxd_align, busy, done, aligned, failed, lane
  );
endinterface

// File: rtl/lvds_align_ctrl.sv
// Word-alignment sequencer for one camera LVDS receiver (cam_N_rxc domain).
// Walks the lanes one at a time, pulsing the deserializer bitslip until the
// lane word holds TRAIN for CHECK_CYC consecutive cycles, or gives the lane
// up as failed after MAX_SLIPS slips.
module lvds_align_ctrl #(
  parameter int          NLANES     = 5,
  parameter logic [7:0]  TRAIN      = 8'h3A,
  parameter int          SETTLE_CYC = 16,
  parameter int          CHECK_CYC  = 32,
  parameter int          MAX_SLIPS  = 8
) (
  input  logic           c,
  input  logic           rst_n,
  lvds_align_ctrl_if.slave bus
);
  localparam int LW = (NLANES > 1)     ? $clog2(NLANES)        : 1;
  localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC)    : 1;
  localparam int MW = $clog2(CHECK_CYC + 1);
  localparam int KW = (MAX_SLIPS > 0)  ? $clog2(MAX_SLIPS + 1) : 1;

  typedef enum logic [2:0] {
    IDLE, LOCK_WAIT, SETTLE, CHECK, SLIP, NEXT, DONE
  } state_t;

  state_t            state_q, state_d;
  logic [LW-1:0]     lane_q, lane_d;
  logic [SW-1:0]     settle_q, settle_d;
  logic [MW-1:0]     match_q, match_d;
  logic [KW-1:0]     slips_q, slips_d;
  logic [NLANES-1:0] aligned_q, aligned_d;
  logic [NLANES-1:0] failed_q, failed_d;
  logic [1:0]        rst_sync_q;
  logic              rst_int_n;
  logic [7:0]        word;
  logic              busy;

  // Reset asserts immediately, deasserts two c edges after rst_n rises.
  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_int_n = rst_sync_q[1];

  // Pick the word of the lane currently being aligned.
  always_comb begin
    word = '0;
    for (int i = 0; i < NLANES; i++)
      if (lane_q == LW'(i)) word = bus.lanes[8*i +: 8];
  end

  assign busy = (state_q != IDLE) && (state_q != DONE);

  // Sequencer state and counters.
  always_ff @(posedge c or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q   <= IDLE;
      lane_q    <= '0;
      settle_q  <= '0;
      match_q   <= '0;
      slips_q   <= '0;
      aligned_q <= '0;
      failed_q  <= '0;
    end else begin
      state_q   <= state_d;
      lane_q    <= lane_d;
      settle_q  <= settle_d;
      match_q   <= match_d;
      slips_q   <= slips_d;
      aligned_q <= aligned_d;
      failed_q  <= failed_d;
    end
  end

  // Next state; a lock loss anywhere in the run overrides everything and restarts.
  always_comb begin
    state_d   = state_q;
    lane_d    = lane_q;
    settle_d  = settle_q;
    match_d   = match_q;
    slips_d   = slips_q;
    aligned_d = aligned_q;
    failed_d  = failed_q;
    unique case (state_q)
      IDLE, DONE: if (bus.start) begin
        aligned_d = '0;
        failed_d  = '0;
        lane_d    = '0;
        slips_d   = '0;
        state_d   = LOCK_WAIT;
      end
      LOCK_WAIT: if (bus.rx_locked) begin
        settle_d = SW'(SETTLE_CYC - 1);
        state_d  = SETTLE;
      end
      SETTLE: begin
        if (settle_q == '0) begin
          match_d = '0;
          state_d = CHECK;
        end else begin
          settle_d = settle_q - SW'(1);
        end
      end
      CHECK: begin
        if (match_q == MW'(CHECK_CYC)) begin
          aligned_d[lane_q] = 1'b1;
          state_d           = NEXT;
        end else if (word == TRAIN) begin
          match_d = match_q + MW'(1);
        end else if (slips_q < KW'(MAX_SLIPS)) begin
          state_d = SLIP;          // partial match count is discarded
        end else begin
          failed_d[lane_q] = 1'b1;
          state_d          = NEXT;
        end
      end
      SLIP: begin
        slips_d  = slips_q + KW'(1);
        settle_d = SW'(SETTLE_CYC - 1);
        state_d  = SETTLE;
      end
      NEXT: begin
        slips_d = '0;
        if (lane_q == LW'(NLANES - 1)) begin
          state_d = DONE;
        end else begin
          lane_d   = lane_q + LW'(1);
          settle_d = SW'(SETTLE_CYC - 1);
          state_d  = SETTLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (busy && !bus.rx_locked) begin
      aligned_d = '0;
      failed_d  = '0;
      slips_d   = '0;
      lane_d    = '0;
      state_d   = LOCK_WAIT;
    end
  end

  // Bitslip pulse for the active lane during SLIP, suppressed if lock is lost.
  always_comb begin
    bus.rxd_align = '0;
    for (int i = 0; i < NLANES; i++)
      bus.rxd_align[i] = (state_q == SLIP) && bus.rx_locked && (lane_q == LW'(i));
  end

  assign bus.busy    = busy;
  assign bus.done    = (state_q == DONE);
  assign bus.aligned = aligned_q;
  assign bus.failed  = failed_q;
  assign bus.lane    = lane_q;
endmodule

// File: tb/tb_lvds_align_ctrl.sv
// Directed bench for lvds_align_ctrl: a lane model that rotates one bit per
// bitslip pulse, a table of full runs, and hand sequences for lock loss,
// late mismatch, reset mid-slip and start handling.
module tb_lvds_align_ctrl;
  localparam int         NL    = 5;
  localparam logic [7:0] TRAIN = 8'h3A;

  logic c = 1'b0;
  logic rst_n = 1'b0;
  always #5 c = ~c;

  lvds_align_ctrl_if #(.NLANES(NL)) bus();

  lvds_align_ctrl #(
    .NLANES(NL), .TRAIN(TRAIN), .SETTLE_CYC(16), .CHECK_CYC(32), .MAX_SLIPS(8)
  ) dut (
    .c(c), .rst_n(rst_n), .bus(bus)
  );

  int   total = 0;
  int   bad   = 0;
  int   need_m [NL];   // slips a lane needs before it shows TRAIN; 255 = stuck at 0
  int   pcnt   [NL];   // bitslip pulses seen per lane
  int   viol = 0;      // cycles with >1 slip bit or aligned&failed overlap
  logic clr = 1'b0;
  logic glitch0 = 1'b0;

  // Count slip pulses per lane and watch the invariants every cycle.
  always @(posedge c) begin
    for (int i = 0; i < NL; i++)
      if (clr) pcnt[i] <= 0;
      else if (bus.rxd_align[i]) pcnt[i] <= pcnt[i] + 1;
    if ($countones(bus.rxd_align) > 1 || (bus.aligned & bus.failed) != '0)
      viol <= viol + 1;
  end

  // Lane words: rotated TRAIN until enough slips have arrived.
  always_comb begin
    logic [7:0] w;
    int r;
    w = '0;
    r = 0;
    bus.lanes = '0;
    for (int i = 0; i < NL; i++) begin
      if (need_m[i] == 255) w = 8'h00;
      else if (pcnt[i] >= need_m[i]) w = TRAIN;
      else begin
        r = ((need_m[i] - pcnt[i] - 1) % 7) + 1;
        w = (TRAIN << r) | (TRAIN >> (8 - r));
      end
      if (i == 0 && glitch0) w = 8'h00;
      bus.lanes[8*i +: 8] = w;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic clr_cnt();
    clr = 1'b1;
    @(posedge c); #1;
    clr = 1'b0;
  endtask

  // Leaves the bench 1 time unit after the edge that sampled start.
  task automatic start_pulse();
    bus.start = 1'b1;
    @(posedge c); #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(inout int cyc);
    while (!bus.done && cyc < 3000) begin
      @(posedge c); #1;
      cyc++;
    end
    chk("done_reached", {31'd0, bus.done}, 32'd1);
  endtask

  task automatic all_need(input int v);
    for (int i = 0; i < NL; i++) need_m[i] = v;
  endtask

  typedef struct packed {
    logic [NL-1:0][7:0] need;
    logic [NL-1:0][7:0] exp_p;
    logic [NL-1:0]      exp_al;
    logic [NL-1:0]      exp_fl;
    logic [15:0]        exp_cyc;
  } vec_t;

  vec_t vt [5];
  int   cyc;

  initial begin
    // clean / rotator lane2 / stuck sync lane / 8 slips ok + 8 slips fail / mixed
    vt[0] = '{need: {8'd0, 8'd0, 8'd0, 8'd0, 8'd0},   exp_p: {8'd0, 8'd0, 8'd0, 8'd0, 8'd0},
              exp_al: 5'h1F, exp_fl: 5'h00, exp_cyc: 16'd251};
    vt[1] = '{need: {8'd0, 8'd0, 8'd3, 8'd0, 8'd0},   exp_p: {8'd0, 8'd0, 8'd3, 8'd0, 8'd0},
              exp_al: 5'h1F, exp_fl: 5'h00, exp_cyc: 16'd305};
    vt[2] = '{need: {8'd255, 8'd0, 8'd0, 8'd0, 8'd0}, exp_p: {8'd8, 8'd0, 8'd0, 8'd0, 8'd0},
              exp_al: 5'h0F, exp_fl: 5'h10, exp_cyc: 16'd363};
    vt[3] = '{need: {8'd0, 8'd9, 8'd0, 8'd0, 8'd8},   exp_p: {8'd0, 8'd8, 8'd0, 8'd0, 8'd8},
              exp_al: 5'h17, exp_fl: 5'h08, exp_cyc: 16'd507};
    vt[4] = '{need: {8'd7, 8'd0, 8'd0, 8'd1, 8'd0},   exp_p: {8'd7, 8'd0, 8'd0, 8'd1, 8'd0},
              exp_al: 5'h1F, exp_fl: 5'h00, exp_cyc: 16'd395};

    bus.start = 1'b0;
    bus.rx_locked = 1'b1;
    all_need(0);

    // reset state
    #12;
    chk("rst_busy",    {31'd0, bus.busy}, 32'd0);
    chk("rst_done",    {31'd0, bus.done}, 32'd0);
    chk("rst_aligned", {27'd0, bus.aligned}, 32'd0);
    chk("rst_failed",  {27'd0, bus.failed}, 32'd0);
    chk("rst_lane",    {29'd0, bus.lane}, 32'd0);
    chk("rst_align",   {27'd0, bus.rxd_align}, 32'd0);
    @(posedge c); #1 rst_n = 1'b1;
    repeat (4) @(posedge c);
    #1;

    // table of full runs
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < NL; i++) need_m[i] = int'(vt[k].need[i]);
      clr_cnt();
      start_pulse();
      chk($sformatf("v%0d_busy_rise", k), {31'd0, bus.busy}, 32'd1);
      cyc = 0;
      wait_done(cyc);
      chk($sformatf("v%0d_cycles", k), cyc, 32'(vt[k].exp_cyc));
      chk($sformatf("v%0d_aligned", k), {27'd0, bus.aligned}, {27'd0, vt[k].exp_al});
      chk($sformatf("v%0d_failed", k),  {27'd0, bus.failed},  {27'd0, vt[k].exp_fl});
      chk($sformatf("v%0d_busy_end", k), {31'd0, bus.busy}, 32'd0);
      for (int i = 0; i < NL; i++)
        chk($sformatf("v%0d_pulses%0d", k, i), pcnt[i], 32'(vt[k].exp_p[i]));
    end

    // single mismatch on lane 0 while the match count is 31
    all_need(0);
    clr_cnt();
    start_pulse();
    repeat (48) @(posedge c);
    #1 glitch0 = 1'b1;
    @(posedge c); #1;
    glitch0 = 1'b0;
    chk("late_mis_slip", {27'd0, bus.rxd_align}, 32'h01);
    cyc = 49;
    wait_done(cyc);
    chk("late_mis_cycles", cyc, 32'd300);
    chk("late_mis_pulses", pcnt[0], 32'd1);
    chk("late_mis_aligned", {27'd0, bus.aligned}, 32'h1F);

    // lock drop during lane 3 CHECK
    all_need(0);
    clr_cnt();
    start_pulse();
    repeat (179) @(posedge c);
    #1;
    chk("drop_pre_aligned", {27'd0, bus.aligned}, 32'h07);
    chk("drop_pre_lane", {29'd0, bus.lane}, 32'd3);
    bus.rx_locked = 1'b0;
    @(posedge c); #1;
    chk("drop_aligned", {27'd0, bus.aligned}, 32'd0);
    chk("drop_lane", {29'd0, bus.lane}, 32'd0);
    chk("drop_busy", {31'd0, bus.busy}, 32'd1);
    bus.rx_locked = 1'b1;
    cyc = 0;
    wait_done(cyc);
    chk("drop_rerun_cycles", cyc, 32'd251);
    chk("drop_rerun_aligned", {27'd0, bus.aligned}, 32'h1F);

    // lock drop inside a SLIP cycle: the pulse must be withheld
    need_m[0] = 2;
    clr_cnt();
    start_pulse();
    repeat (18) @(posedge c);
    #1;
    chk("slipdrop_vis", {27'd0, bus.rxd_align}, 32'h01);
    bus.rx_locked = 1'b0;
    #1;
    chk("slipdrop_gated", {27'd0, bus.rxd_align}, 32'd0);
    @(posedge c); #1;
    chk("slipdrop_nopulse", pcnt[0], 32'd0);
    chk("slipdrop_lane", {29'd0, bus.lane}, 32'd0);
    bus.rx_locked = 1'b1;
    cyc = 0;
    wait_done(cyc);
    chk("slipdrop_cycles", cyc, 32'd287);
    chk("slipdrop_pulses", pcnt[0], 32'd2);

    // reset asserted mid-SLIP on the stuck sync lane
    all_need(0);
    need_m[4] = 255;
    clr_cnt();
    start_pulse();
    cyc = 0;
    while (bus.rxd_align == '0 && cyc < 1000) begin
      @(posedge c); #1;
      cyc++;
    end
    chk("rstslip_at", cyc, 32'd218);
    chk("rstslip_pulse", {27'd0, bus.rxd_align}, 32'h10);
    #1 rst_n = 1'b0;
    #1;
    chk("rstslip_align", {27'd0, bus.rxd_align}, 32'd0);
    chk("rstslip_busy", {31'd0, bus.busy}, 32'd0);
    chk("rstslip_aligned", {27'd0, bus.aligned}, 32'd0);
    chk("rstslip_lane", {29'd0, bus.lane}, 32'd0);
    repeat (3) @(posedge c);
    #1 rst_n = 1'b1;
    repeat (4) @(posedge c);
    #1;

    // start while busy is ignored, start in DONE reruns
    all_need(0);
    clr_cnt();
    start_pulse();
    repeat (120) @(posedge c);
    #1;
    start_pulse();
    chk("ign_lane", {29'd0, bus.lane}, 32'd2);
    chk("ign_aligned", {27'd0, bus.aligned}, 32'h03);
    cyc = 121;
    wait_done(cyc);
    chk("ign_cycles", cyc, 32'd251);
    start_pulse();
    chk("rerun_busy", {31'd0, bus.busy}, 32'd1);
    chk("rerun_cleared", {27'd0, bus.aligned}, 32'd0);
    cyc = 0;
    wait_done(cyc);
    chk("rerun_cycles", cyc, 32'd251);
    chk("rerun_aligned", {27'd0, bus.aligned}, 32'h1F);

    chk("invariants", viol, 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
